// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter between the MEM stage and the debug port.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DBG_RD = 2'd2
    } owner_e;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating counter with synchronous clear.
// Tracks how many consecutive cycles the debug port has been denied.
module starve_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAXV = W'(MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != MAXV) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: CPU has priority, debug reads are
// forced through after STARVE_MAX consecutive denials.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    owner_e            state;
    owner_e            state_nx;
    logic              rd_cpu;
    logic              rd_dbg;
    logic              cpu_gnt;
    logic              dbg_gnt;
    logic              starve_full;
    logic [CW-1:0]     starve_cnt;
    logic [DATA_W-1:0] cpu_hold;
    logic [DATA_W-1:0] dbg_hold;

    assign rd_cpu = (state == CPU_RD);
    assign rd_dbg = (state == DBG_RD);

    assign starve_full = (starve_cnt == CW'(STARVE_MAX));

    // Debug never gets a new grant in its own return cycle.
    assign dbg_gnt = dbg_req & ~rd_dbg & (~cpu_req | starve_full);
    assign cpu_gnt = cpu_req & ~dbg_gnt;

    starve_counter #(
        .MAX (STARVE_MAX),
        .W   (CW)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (dbg_req & ~dbg_gnt),
        .clr   (~dbg_req | dbg_gnt | rd_dbg),
        .cnt   (starve_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = IDLE;
        unique case (1'b1)
            dbg_gnt:           state_nx = DBG_RD;
            cpu_gnt & ~cpu_we: state_nx = CPU_RD;
            default:           state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_hold <= '0;
            dbg_hold <= '0;
        end else begin
            if (rd_cpu) cpu_hold <= mem_rdata;
            if (rd_dbg) dbg_hold <= mem_rdata;
        end
    end

    always_comb begin
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        cpu_stall  = 1'b0;
        cpu_rvalid = 1'b0;
        dbg_rvalid = 1'b0;
        cpu_rdata  = cpu_hold;
        dbg_rdata  = dbg_hold;
        if (rst_n) begin
            mem_en     = cpu_gnt | dbg_gnt;
            mem_we     = cpu_gnt & cpu_we;
            cpu_stall  = cpu_req & dbg_gnt;
            cpu_rvalid = rd_cpu;
            dbg_rvalid = rd_dbg;
            if (dbg_gnt) begin
                mem_addr = dbg_addr;
            end else if (cpu_gnt) begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            if (rd_cpu) cpu_rdata = mem_rdata;
            if (rd_dbg) dbg_rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        dbg_req;
    logic [7:0]  dbg_addr;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        cpu_stall;
    logic [31:0] dbg_rdata;
    logic        dbg_rvalid;

    logic [31:0] mem [256];
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_stall  (cpu_stall),
        .dbg_rdata  (dbg_rdata),
        .dbg_rvalid (dbg_rvalid)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h05] = 32'h0000_1234;
        mem_rdata = 32'h0;
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h0; cpu_wdata = 32'h0;
        dbg_req = 1'b0; dbg_addr = 8'h0;

        mid();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
        chk("rst_stall", cpu_stall, 0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // CPU load only
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        mid();
        chk("ld_mem_en", mem_en, 1);
        chk("ld_mem_we", mem_we, 0);
        chk("ld_mem_addr", mem_addr, 8'h10);
        chk("ld_stall", cpu_stall, 0);
        next_cycle();
        cpu_req = 1'b0;
        mid();
        chk("ld_rvalid", cpu_rvalid, 1);
        chk("ld_rdata", cpu_rdata, 32'hDEADBEEF);
        next_cycle();
        mid();
        chk("ld_rvalid_off", cpu_rvalid, 0);
        chk("ld_rdata_hold", cpu_rdata, 32'hDEADBEEF);

        // Debug only
        next_cycle();
        dbg_req = 1'b1; dbg_addr = 8'h05;
        mid();
        chk("dbg_mem_en", mem_en, 1);
        chk("dbg_mem_addr", mem_addr, 8'h05);
        chk("dbg_rvalid0", dbg_rvalid, 0);
        next_cycle();
        mid();
        chk("dbg_rvalid1", dbg_rvalid, 1);
        chk("dbg_rdata", dbg_rdata, 32'h1234);
        chk("dbg_no_regrant", mem_en, 0);
        next_cycle();
        dbg_req = 1'b0;
        mid();
        chk("dbg_rvalid_off", dbg_rvalid, 0);
        chk("dbg_rdata_hold", dbg_rdata, 32'h1234);

        // Starvation: CPU loads every cycle while debug waits
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        dbg_req = 1'b1; dbg_addr = 8'h05;
        for (int c = 0; c < 4; c++) begin
            mid();
            chk($sformatf("stv_cpu_addr_c%0d", c), mem_addr, 8'h10);
            chk($sformatf("stv_stall_c%0d", c), cpu_stall, 0);
            chk($sformatf("stv_dbg_rv_c%0d", c), dbg_rvalid, 0);
            next_cycle();
        end
        mid();
        chk("stv_dbg_addr_c4", mem_addr, 8'h05);
        chk("stv_stall_c4", cpu_stall, 1);
        chk("stv_cpu_rv_c4", cpu_rvalid, 1);
        next_cycle();
        mid();
        chk("stv_dbg_rv_c5", dbg_rvalid, 1);
        chk("stv_dbg_rdata_c5", dbg_rdata, 32'h1234);
        chk("stv_cpu_rv_c5", cpu_rvalid, 0);
        chk("stv_cpu_addr_c5", mem_addr, 8'h10);
        chk("stv_stall_c5", cpu_stall, 0);
        next_cycle();
        cpu_req = 1'b0; dbg_req = 1'b0;
        mid();
        chk("stv_cpu_rv_c6", cpu_rvalid, 1);
        chk("stv_dbg_rv_c6", dbg_rvalid, 0);
        next_cycle();

        // Collision: store and debug read to the same address
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 32'hAA;
        dbg_req = 1'b1; dbg_addr = 8'h20;
        mid();
        chk("col_we", mem_we, 1);
        chk("col_addr", mem_addr, 8'h20);
        chk("col_wdata", mem_wdata, 32'hAA);
        chk("col_stall", cpu_stall, 0);
        next_cycle();
        cpu_req = 1'b0; cpu_we = 1'b0;
        mid();
        chk("col_dbg_gnt", mem_en, 1);
        chk("col_dbg_we", mem_we, 0);
        chk("col_st_rvalid", cpu_rvalid, 0);
        next_cycle();
        mid();
        chk("col_dbg_rv", dbg_rvalid, 1);
        chk("col_dbg_rdata", dbg_rdata, 32'hAA);
        next_cycle();
        dbg_req = 1'b0;
        next_cycle();

        // Reset while a load is in flight
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        mid();
        chk("rmr_gnt", mem_en, 1);
        rst_n = 1'b0;
        #1;
        chk("rmr_mem_en", mem_en, 0);
        chk("rmr_mem_addr", mem_addr, 0);
        chk("rmr_cpu_rdata", cpu_rdata, 0);
        chk("rmr_dbg_rdata", dbg_rdata, 0);
        chk("rmr_stall", cpu_stall, 0);
        cpu_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            chk($sformatf("rmr_rv_rst%0d", c), cpu_rvalid, 0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            mid();
            chk($sformatf("rmr_rv_post%0d", c), cpu_rvalid, 0);
            chk($sformatf("rmr_dbg_rv_post%0d", c), dbg_rvalid, 0);
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
